// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - digit inputs, load strobe and scan outputs of the display sequencer
interface display_scan_ctrl_if;
  logic       load;
  logic [3:0] n_0f, n_1f, n_2f, n_3f;
  logic [3:0] n_0C, n_1C, n_2C, n_3C;
  logic [3:0] an;
  logic [3:0] bcd;
  logic       src_sel;
  logic       bcd_err;

  modport master (
    output load, n_0f, n_1f, n_2f, n_3f, n_0C, n_1C, n_2C, n_3C,
    input  an, bcd, src_sel, bcd_err
  );

  modport slave (
    input  load, n_0f, n_1f, n_2f, n_3f, n_0C, n_1C, n_2C, n_3C,
    output an, bcd, src_sel, bcd_err
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - four-digit 7-segment scan sequencer with source debounce,
// shadow capture and leading-zero blanking
module display_scan_ctrl #(
  parameter int REFRESH_DIV     = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                switch,
  display_scan_ctrl_if.slave  disp
);

  localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             sw_m, sw_s;
  logic             src_q;
  logic [DEB_W-1:0] deb_cnt;
  logic             reload_pend;
  logic [3:0][3:0]  shadow;
  logic [REF_W-1:0] ref_cnt;
  logic [1:0]       scan_idx;
  logic [3:0]       an_q, bcd_q;
  logic             err_q;

  logic [3:0][3:0]  sel_digits;
  logic             blank;
  logic [3:0]       digit_en;
  logic [3:0]       cur_digit;

  assign sel_digits = src_q ? {disp.n_3f, disp.n_2f, disp.n_1f, disp.n_0f}
                            : {disp.n_3C, disp.n_2C, disp.n_1C, disp.n_0C};
  assign cur_digit  = shadow[scan_idx];

  // Blanking looks only at zero digits above the slot; nonzero (incl. invalid) values always show.
  always_comb begin
    blank = 1'b0;
    case (scan_idx)
      2'd3:    blank = (shadow[3] == 4'd0);
      2'd2:    blank = (shadow[3] == 4'd0) && (shadow[2] == 4'd0);
      2'd1:    blank = (shadow[3] == 4'd0) && (shadow[2] == 4'd0) && (shadow[1] == 4'd0);
      default: blank = 1'b0;
    endcase
  end

  always_comb begin
    digit_en = 4'b1111;
    if (!blank) digit_en[scan_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_m        <= 1'b0;
      sw_s        <= 1'b0;
      src_q       <= 1'b0;
      deb_cnt     <= '0;
      reload_pend <= 1'b0;
      shadow      <= '0;
      ref_cnt     <= '0;
      scan_idx    <= 2'd0;
      an_q        <= 4'b1111;
      bcd_q       <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      sw_m <= switch;
      sw_s <= sw_m;

      reload_pend <= 1'b0;
      if (sw_s == src_q) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        src_q       <= ~src_q;
        deb_cnt     <= '0;
        reload_pend <= 1'b1;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end

      // A load coinciding with the post-toggle reload is the same single capture from the new source.
      if (disp.load || reload_pend) shadow <= sel_digits;

      if (ref_cnt == REF_LAST) begin
        ref_cnt  <= '0;
        scan_idx <= scan_idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + REF_W'(1);
      end

      an_q  <= digit_en;
      bcd_q <= cur_digit;
      err_q <= (cur_digit > 4'd9);
    end
  end

  assign disp.an      = an_q;
  assign disp.bcd     = bcd_q;
  assign disp.src_sel = src_q;
  assign disp.bcd_err = err_q;

endmodule
